usb_phy_tx: RTL and testbench



---
 rtl/usb_pkg.sv | 24 ++
 rtl/usb_tx_nrzi.sv | 50 +++++
 rtl/usb_phy_tx.sv | 171 +++++++++++++++++
 tb/tb_usb_phy_tx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB transmit path.
//   usb_tx_state_t : transmitter FSM states
//   usb_line_t     : {dp, dn} drive encodings for J, K and SE0
package usb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEopSe0,
    StEopJ
  } usb_tx_state_t;

  typedef enum logic [1:0] {
    LineSe0 = 2'b00,
    LineK   = 2'b01,
    LineJ   = 2'b10
  } usb_line_t;

  localparam logic [7:0]  USB_SYNC         = 8'h80;
  localparam int unsigned USB_STUFF_LEN    = 6;
  localparam int unsigned USB_EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_nrzi.sv
// Bit-stuff counter and NRZI level register.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   bit_start_i    : a new bit period begins at the coming edge
//   bit_i          : value of that bit (0 for a stuff bit)
//   pkt_start_i    : first bit of a packet; level restarts from J, run count from 0
//   level_o        : line level for the starting bit (1 = J, 0 = K), held otherwise
//   stuff_req_o    : a run of USB_STUFF_LEN ones has just been sent
module usb_tx_nrzi
  import usb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic bit_start_i,
  input  logic bit_i,
  input  logic pkt_start_i,
  output logic level_o,
  output logic stuff_req_o
);

  logic       level_q, level_d;
  logic [2:0] ones_q, ones_d;
  logic       base_level;
  logic [2:0] base_ones;

  always_comb begin
    base_level = pkt_start_i ? 1'b1 : level_q;
    base_ones  = pkt_start_i ? 3'd0 : ones_q;
    level_d    = level_q;
    ones_d     = ones_q;
    if (bit_start_i) begin
      // NRZI: a 0 toggles, a 1 holds.
      level_d = bit_i ? base_level : ~base_level;
      ones_d  = bit_i ? base_ones + 3'd1 : 3'd0;
    end
  end

  assign level_o     = level_d;
  assign stuff_req_o = (ones_q == 3'(USB_STUFF_LEN));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
      ones_q  <= 3'd0;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: rtl/usb_phy_tx.sv
// Full-speed USB line transmitter: SYNC, LSB-first serialisation with bit stuffing,
// NRZI, then EOP (2 bits SE0, 1 bit J).
//   clk_48m, rst               : 48 MHz clock, asynchronous active-high reset
//   tx_valid/tx_data/tx_last   : byte stream from the protocol engine
//   tx_ready                   : byte consumed this cycle (load point)
//   tx_busy                    : packet in progress (tracks output enable)
//   tx_underrun                : no byte available at a load point; packet ends
//   usb_dp_tx/usb_dn_tx        : registered line levels
//   usb_tx_oen                 : 1 while the transmitter drives the lines
module usb_phy_tx
  import usb_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 4
) (
  input  logic       clk_48m,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       usb_dp_tx,
  output logic       usb_dn_tx,
  output logic       usb_tx_oen
);

  localparam int unsigned       TimerW    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BIT_CLKS - 1);

  usb_tx_state_t     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              last_q, last_d;
  usb_line_t         line_q, line_d;
  logic              oen_q, oen_d;

  logic bit_end, bit_start, bit_val, pkt_start;
  logic nrzi_level, stuff_req;

  usb_tx_nrzi u_nrzi (
    .clk_i      (clk_48m),
    .rst_i      (rst),
    .bit_start_i(bit_start),
    .bit_i      (bit_val),
    .pkt_start_i(pkt_start),
    .level_o    (nrzi_level),
    .stuff_req_o(stuff_req)
  );

  assign bit_end = (timer_q == TimerLast);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    last_d      = last_q;
    oen_d       = oen_q;
    bit_start   = 1'b0;
    bit_val     = 1'b0;
    pkt_start   = 1'b0;
    tx_ready    = 1'b0;
    tx_underrun = 1'b0;

    if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          // SYNC goes through the same shifter as data, with no last flag.
          state_d   = StSync;
          pkt_start = 1'b1;
          bit_start = 1'b1;
          bit_val   = USB_SYNC[0];
          shift_d   = USB_SYNC;
          last_d    = 1'b0;
          bit_cnt_d = 3'd0;
          oen_d     = 1'b1;
          timer_d   = '0;
        end
      end
      StSync, StData: begin
        if (bit_end) begin
          if (stuff_req) begin
            bit_start = 1'b1;
            bit_val   = 1'b0;
          end else if (bit_cnt_q != 3'd7) begin
            bit_start = 1'b1;
            bit_val   = shift_q[1];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (last_q) begin
            state_d   = StEopSe0;
            bit_cnt_d = 3'd0;
          end else if (tx_valid) begin
            // Load point: the final clock of SYNC or of the previous byte.
            tx_ready  = 1'b1;
            state_d   = StData;
            shift_d   = tx_data;
            last_d    = tx_last;
            bit_cnt_d = 3'd0;
            bit_start = 1'b1;
            bit_val   = tx_data[0];
          end else begin
            tx_underrun = 1'b1;
            state_d     = StEopSe0;
            bit_cnt_d   = 3'd0;
          end
        end
      end
      StEopSe0: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'(USB_EOP_SE0_BITS - 1)) begin
            state_d = StEopJ;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (bit_end) begin
          state_d = StIdle;
          oen_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Kept apart from the FSM block: nrzi_level depends combinationally on bit_start.
  always_comb begin
    line_d = line_q;
    if (bit_start) begin
      line_d = nrzi_level ? LineJ : LineK;
    end else if (state_d == StEopSe0) begin
      line_d = LineSe0;
    end else if (state_d == StEopJ || state_d == StIdle) begin
      line_d = LineJ;
    end
  end

  always_ff @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      last_q    <= 1'b0;
      line_q    <= LineJ;
      oen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      line_q    <= line_d;
      oen_q     <= oen_d;
    end
  end

  assign usb_dp_tx  = line_q[1];
  assign usb_dn_tx  = line_q[0];
  assign usb_tx_oen = oen_q;
  assign tx_busy    = oen_q;

endmodule

// File: tb/tb_usb_phy_tx.sv
// Self-checking bench for usb_phy_tx. A reference model turns each packet into a
// per-cycle list of expected {oen, dp, dn, busy, ready, underrun}; the monitor
// captures the DUT on falling edges and each test pops and compares.
module tb_usb_phy_tx;

  localparam int BitClks = 4;

  logic       clk_48m, rst;
  logic       tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_underrun;
  logic       usb_dp_tx, usb_dn_tx, usb_tx_oen;

  usb_phy_tx #(.BIT_CLKS(BitClks)) dut (
    .clk_48m    (clk_48m),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_underrun(tx_underrun),
    .usb_dp_tx  (usb_dp_tx),
    .usb_dn_tx  (usb_dn_tx),
    .usb_tx_oen (usb_tx_oen)
  );

  initial clk_48m = 1'b0;
  always #5 clk_48m = ~clk_48m;

  logic [5:0] obs_now;
  assign obs_now = {usb_tx_oen, usb_dp_tx, usb_dn_tx, tx_busy, tx_ready, tx_underrun};

  localparam logic [5:0] EIdle = 6'b010000;
  localparam logic [5:0] ESe0  = 6'b100100;
  localparam logic [5:0] EJ    = 6'b110100;

  int         n_vec, n_err;
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int         ready_idx[$];
  int         und_idx, se0_idx, fall_idx, first_oen_idx, oen_cnt;
  bit         drv_timeout;
  logic [7:0] pkt_data[0:3];
  logic       m_lvl;
  int         m_ones;

  task automatic push_level(input logic lvl);
    for (int c = 0; c < BitClks; c++) exp_q.push_back({1'b1, lvl, ~lvl, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) m_lvl = ~m_lvl;
      push_level(m_lvl);
      m_ones = b[i] ? m_ones + 1 : 0;
      if (m_ones == 6) begin
        m_lvl  = ~m_lvl;
        push_level(m_lvl);
        m_ones = 0;
      end
    end
  endtask

  task automatic mark_last(input logic [5:0] m);
    logic [5:0] e;
    e = exp_q.pop_back();
    exp_q.push_back(e | m);
  endtask

  task automatic build_expected(input int n_send, input bit has_last);
    exp_q.delete();
    exp_q.push_back(EIdle);
    m_lvl  = 1'b1;
    m_ones = 0;
    model_byte(8'h80);
    for (int i = 0; i < n_send; i++) begin
      mark_last(6'b000010);
      model_byte(pkt_data[i]);
    end
    if (!has_last) mark_last(6'b000001);
    repeat (2 * BitClks) exp_q.push_back(ESe0);
    repeat (BitClks) exp_q.push_back(EJ);
    exp_q.push_back(EIdle);
  endtask

  // Must be entered at a falling edge; that cycle is cycle 0.
  task automatic run_packet(input int n_send, input bit has_last);
    int n_cyc, idx, guard;
    build_expected(n_send, has_last);
    obs_q.delete();
    ready_idx.delete();
    und_idx = -1; se0_idx = -1; fall_idx = -1; first_oen_idx = -1;
    oen_cnt = 0; drv_timeout = 1'b0;
    n_cyc    = exp_q.size();
    tx_data  = pkt_data[0];
    tx_last  = has_last && (n_send == 1);
    tx_valid = 1'b1;
    fork
      begin
        idx = 0; guard = 0;
        while (idx < n_send && guard < 1000) begin
          @(negedge clk_48m);
          guard++;
          if (tx_ready) begin
            @(posedge clk_48m);
            #1;
            idx++;
            if (idx < n_send) begin
              tx_data = pkt_data[idx];
              tx_last = has_last && (idx == n_send - 1);
            end else begin
              tx_valid = 1'b0;
              tx_last  = 1'b0;
            end
          end
        end
        if (idx < n_send) drv_timeout = 1'b1;
      end
      begin
        for (int k = 0; k < n_cyc; k++) begin
          if (k > 0) @(negedge clk_48m);
          obs_q.push_back(obs_now);
          if (usb_tx_oen) oen_cnt++;
          if (usb_tx_oen && first_oen_idx < 0) first_oen_idx = k;
          if (tx_ready) ready_idx.push_back(k);
          if (tx_underrun) und_idx = k;
          if (se0_idx < 0 && usb_tx_oen && !usb_dp_tx && !usb_dn_tx) se0_idx = k;
          if (fall_idx < 0 && k > 1 && !tx_busy) fall_idx = k;
        end
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (3) @(negedge clk_48m);
    n_vec++;
    if (obs_now !== EIdle) begin
      n_err++; $display("FAIL reset_state: got %b want %b", obs_now, EIdle);
    end
    tx_valid = 1'b1;
    @(negedge clk_48m);
    n_vec++;
    if (obs_now !== EIdle) begin
      n_err++; $display("FAIL reset_holds: got %b want %b", obs_now, EIdle);
    end
    tx_valid = 1'b0;
    @(posedge clk_48m); #2; rst = 1'b0;
    repeat (2) @(negedge clk_48m);
    n_vec++;
    if (obs_now !== EIdle) begin
      n_err++; $display("FAIL idle_after_reset: got %b want %b", obs_now, EIdle);
    end
  endtask

  task automatic test_single_zero();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'h00;
    run_packet(1, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL zero_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (oen_cnt !== 76) begin n_err++; $display("FAIL zero_oen_len: got %0d want 76", oen_cnt); end
    n_vec++;
    if (se0_idx !== 65) begin n_err++; $display("FAIL zero_eop_start: got %0d want 65", se0_idx); end
    n_vec++;
    if (drv_timeout !== 1'b0) begin n_err++; $display("FAIL zero_ready_timeout: got 1 want 0"); end
  endtask

  task automatic test_single_ff();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'hFF;
    run_packet(1, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL ff_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (oen_cnt !== 80) begin n_err++; $display("FAIL ff_oen_len: got %0d want 80", oen_cnt); end
    n_vec++;
    if (se0_idx !== 69) begin n_err++; $display("FAIL ff_eop_start: got %0d want 69", se0_idx); end
  endtask

  task automatic test_two_bytes();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'hA5; pkt_data[1] = 8'h3C;
    run_packet(2, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL two_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (ready_idx.size() !== 2) begin
      n_err++; $display("FAIL two_ready_count: got %0d want 2", ready_idx.size());
    end else begin
      n_vec++;
      if (ready_idx[0] !== 32 || ready_idx[1] !== 64) begin
        n_err++;
        $display("FAIL two_ready_cycles: got %0d,%0d want 32,64", ready_idx[0], ready_idx[1]);
      end
    end
    n_vec++;
    if (se0_idx !== 97) begin n_err++; $display("FAIL two_eop_start: got %0d want 97", se0_idx); end
  endtask

  task automatic test_underrun();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'h01;
    run_packet(1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL und_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (und_idx !== 64) begin n_err++; $display("FAIL und_pulse: got %0d want 64", und_idx); end
    n_vec++;
    if (se0_idx !== 65) begin n_err++; $display("FAIL und_se0: got %0d want 65", se0_idx); end
    n_vec++;
    if (fall_idx - se0_idx !== 12) begin
      n_err++; $display("FAIL und_busy_clear: got %0d want 12", fall_idx - se0_idx);
    end
  endtask

  task automatic test_stuff_delay();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'hFC; pkt_data[1] = 8'h00;
    run_packet(2, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL stuff_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (ready_idx.size() !== 2) begin
      n_err++; $display("FAIL stuff_ready_count: got %0d want 2", ready_idx.size());
    end else begin
      n_vec++;
      if (ready_idx[1] !== 68) begin
        n_err++; $display("FAIL stuff_ready_delay: got %0d want 68", ready_idx[1]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int k; logic [5:0] e, o;
    tx_data = 8'h00; tx_last = 1'b1; tx_valid = 1'b1;
    repeat (50) @(posedge clk_48m);
    #1;
    n_vec++;
    if (usb_tx_oen !== 1'b1) begin n_err++; $display("FAIL rst_mid_active: got %b want 1", usb_tx_oen); end
    #1; rst = 1'b1;
    #1;
    n_vec++;
    if (obs_now !== EIdle) begin n_err++; $display("FAIL rst_mid_outputs: got %b want %b", obs_now, EIdle); end
    tx_valid = 1'b0; tx_last = 1'b0;
    repeat (2) @(posedge clk_48m);
    #2; rst = 1'b0;
    @(negedge clk_48m);
    pkt_data[0] = 8'h3C;
    run_packet(1, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL rst_restart_line[%0d]: got %b want %b", k, o, e); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k; logic [5:0] e, o;
    pkt_data[0] = 8'hFC;
    run_packet(1, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b_first[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (fall_idx !== 81) begin n_err++; $display("FAIL b2b_first_fall: got %0d want 81", fall_idx); end
    // Still inside the cycle where busy fell: this is cycle 0 of the next packet.
    pkt_data[0] = 8'h5A;
    run_packet(1, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 6'bx; n_vec++;
      if (o !== e) begin n_err++; $display("FAIL b2b_second[%0d]: got %b want %b", k, o, e); end
      k++;
    end
    n_vec++;
    if (first_oen_idx !== 1) begin
      n_err++; $display("FAIL b2b_sync_start: got %0d want 1", first_oen_idx);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_single_zero();
    test_single_ff();
    test_two_bytes();
    test_underrun();
    test_stuff_delay();
    test_reset_mid_packet();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
